intersection_scheduler: RTL and testbench

- Timed phase scheduler for a two-street intersection (main street A, side street B) with a pedestrian crossing phase.
- Owns a seconds prescaler and a per-phase down-counter, latches vehicle and pedestrian demand, and arbitrates green time between A, B and WALK.
- Drives the six lamp outputs plus the walk signal, with parameterised durations, bounded B extensions and all-red clearance intervals.

---
 rtl/intersection_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_intersection_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// intersection_scheduler
// Timed phase scheduler for a two-street intersection (main street A, side
// street B) with a pedestrian WALK phase. A seconds prescaler feeds a
// per-phase down-counter; vehicle and pedestrian demand are latched and used
// to arbitrate green time between A, B and WALK, with bounded B extensions and
// all-red clearance between conflicting phases.
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   sa, sb     car approaching on A / B (level)
//   ped_req    pedestrian button (pulse or level)
//   ra/ya/ga   A lamps          rb/yb/gb  B lamps
//   walk       pedestrian walk lamp
//   ped_ack    one-cycle pulse on WALK entry
//   phase      current state encoding
//   sec_left   seconds remaining in the current phase
module intersection_scheduler #(
    parameter int TICK_DIV    = 50000000,
    parameter int CNT_W       = 8,
    parameter int MIN_GREEN_A = 60,
    parameter int GREEN_B     = 50,
    parameter int EXT_B       = 10,
    parameter int MAX_EXT     = 6,
    parameter int YELLOW      = 3,
    parameter int ALL_RED     = 1,
    parameter int WALK        = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sa,
    input  logic             sb,
    input  logic             ped_req,
    output logic             ra,
    output logic             ya,
    output logic             ga,
    output logic             rb,
    output logic             yb,
    output logic             gb,
    output logic             walk,
    output logic             ped_ack,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] sec_left
);

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        AR_AB  = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        AR_BX  = 3'd5,
        WALK_S = 3'd6,
        AR_WA  = 3'd7
    } state_t;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EXT_W = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

    state_t           state_r;
    state_t           nxt_state_s;
    logic [PRE_W-1:0] presc_r;
    logic [CNT_W-1:0] sec_r;
    logic             b_pend_r;
    logic             ped_pend_r;
    logic [EXT_W-1:0] ext_cnt_r;
    logic [6:0]       lamp_r;
    logic             ped_ack_r;
    logic             tick_s;
    logic             expire_s;
    logic             extend_s;
    logic             enter_s;

    // Phase duration loaded on entry to each state.
    function automatic logic [CNT_W-1:0] dur_of(input state_t s);
        case (s)
            A_GRN:   dur_of = CNT_W'(MIN_GREEN_A);
            A_YEL:   dur_of = CNT_W'(YELLOW);
            AR_AB:   dur_of = CNT_W'(ALL_RED);
            B_GRN:   dur_of = CNT_W'(GREEN_B);
            B_YEL:   dur_of = CNT_W'(YELLOW);
            AR_BX:   dur_of = CNT_W'(ALL_RED);
            WALK_S:  dur_of = CNT_W'(WALK);
            AR_WA:   dur_of = CNT_W'(ALL_RED);
            default: dur_of = CNT_W'(MIN_GREEN_A);
        endcase
    endfunction

    // Lamp pattern {ra, ya, ga, rb, yb, gb, walk} for each state.
    function automatic logic [6:0] lamps_of(input state_t s);
        case (s)
            A_GRN:   lamps_of = 7'b0011000;
            A_YEL:   lamps_of = 7'b0101000;
            AR_AB:   lamps_of = 7'b1001000;
            B_GRN:   lamps_of = 7'b1000010;
            B_YEL:   lamps_of = 7'b1000100;
            AR_BX:   lamps_of = 7'b1001000;
            WALK_S:  lamps_of = 7'b1001001;
            AR_WA:   lamps_of = 7'b1001000;
            default: lamps_of = 7'b0011000;
        endcase
    endfunction

    assign tick_s   = (presc_r == PRE_W'(TICK_DIV - 1));
    assign expire_s = tick_s && (sec_r == CNT_W'(1));
    assign enter_s  = (nxt_state_s != state_r);

    // Next-state selection and B-extension decision.
    always_comb begin
        nxt_state_s = state_r;
        extend_s    = 1'b0;
        case (state_r)
            A_GRN: begin
                // A rests green after its minimum until someone else wants a turn.
                if ((sec_r == CNT_W'(0)) && (b_pend_r || ped_pend_r)) begin
                    nxt_state_s = A_YEL;
                end else begin
                    nxt_state_s = A_GRN;
                end
            end
            A_YEL: begin
                if (expire_s) nxt_state_s = AR_AB;
                else          nxt_state_s = A_YEL;
            end
            AR_AB: begin
                // Vehicles on B are served before a waiting pedestrian.
                if (expire_s) nxt_state_s = b_pend_r ? B_GRN : WALK_S;
                else          nxt_state_s = AR_AB;
            end
            B_GRN: begin
                if (expire_s) begin
                    if (sb && !sa && !ped_pend_r && (ext_cnt_r < EXT_W'(MAX_EXT))) begin
                        extend_s    = 1'b1;
                        nxt_state_s = B_GRN;
                    end else begin
                        nxt_state_s = B_YEL;
                    end
                end else begin
                    nxt_state_s = B_GRN;
                end
            end
            B_YEL: begin
                if (expire_s) nxt_state_s = AR_BX;
                else          nxt_state_s = B_YEL;
            end
            AR_BX: begin
                if (expire_s) nxt_state_s = ped_pend_r ? WALK_S : A_GRN;
                else          nxt_state_s = AR_BX;
            end
            WALK_S: begin
                if (expire_s) nxt_state_s = AR_WA;
                else          nxt_state_s = WALK_S;
            end
            AR_WA: begin
                if (expire_s) nxt_state_s = A_GRN;
                else          nxt_state_s = AR_WA;
            end
            default: begin
                nxt_state_s = A_GRN;
            end
        endcase
    end

    // State, timers, demand latches and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= A_GRN;
            presc_r    <= PRE_W'(0);
            sec_r      <= CNT_W'(MIN_GREEN_A);
            b_pend_r   <= 1'b0;
            ped_pend_r <= 1'b0;
            ext_cnt_r  <= EXT_W'(0);
            lamp_r     <= 7'b0011000;
            ped_ack_r  <= 1'b0;
        end else begin
            state_r   <= nxt_state_s;
            lamp_r    <= lamps_of(nxt_state_s);
            ped_ack_r <= enter_s && (nxt_state_s == WALK_S);

            // Entry and extension both restart the second boundary from zero.
            if (enter_s) begin
                presc_r <= PRE_W'(0);
                sec_r   <= dur_of(nxt_state_s);
            end else if (extend_s) begin
                presc_r <= PRE_W'(0);
                sec_r   <= CNT_W'(EXT_B);
            end else if (tick_s) begin
                presc_r <= PRE_W'(0);
                if (sec_r != CNT_W'(0)) sec_r <= sec_r - CNT_W'(1);
                else                    sec_r <= sec_r;
            end else begin
                presc_r <= presc_r + PRE_W'(1);
            end

            if (enter_s)       ext_cnt_r <= EXT_W'(0);
            else if (extend_s) ext_cnt_r <= ext_cnt_r + EXT_W'(1);
            else               ext_cnt_r <= ext_cnt_r;

            if (enter_s && (nxt_state_s == B_GRN))  b_pend_r <= 1'b0;
            else if (sb && (state_r != B_GRN))      b_pend_r <= 1'b1;
            else                                    b_pend_r <= b_pend_r;

            // A press coinciding with WALK entry is kept for the next cycle.
            if (ped_req)                                  ped_pend_r <= 1'b1;
            else if (enter_s && (nxt_state_s == WALK_S))  ped_pend_r <= 1'b0;
            else                                          ped_pend_r <= ped_pend_r;
        end
    end

    assign {ra, ya, ga, rb, yb, gb, walk} = lamp_r;
    assign ped_ack  = ped_ack_r;
    assign phase    = state_r;
    assign sec_left = sec_r;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Testbench for intersection_scheduler: table-driven directed vectors with
// hand-computed phase/sec_left/ped_ack values, plus a hand-written sequence
// for asynchronous reset in the middle of B green.
module tb_intersection_scheduler;

    logic       clk;
    logic       reset_n;
    logic       sa;
    logic       sb;
    logic       ped_req;
    logic       ra, ya, ga, rb, yb, gb, walk, ped_ack;
    logic [2:0] phase;
    logic [7:0] sec_left;

    int n_checks = 0;
    int n_fail   = 0;

    intersection_scheduler #(
        .TICK_DIV(4), .CNT_W(8), .MIN_GREEN_A(6), .GREEN_B(5), .EXT_B(2),
        .MAX_EXT(2), .YELLOW(2), .ALL_RED(1), .WALK(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sa(sa), .sb(sb), .ped_req(ped_req),
        .ra(ra), .ya(ya), .ga(ga), .rb(rb), .yb(yb), .gb(gb), .walk(walk),
        .ped_ack(ped_ack), .phase(phase), .sec_left(sec_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        int         n;
        bit         sa;
        bit         sb;
        bit         pls_sb;
        bit         pls_ped;
        logic [2:0] ph;
        logic [7:0] sec;
        bit         ack;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input int n, input bit a, input bit b,
                       input bit psb, input bit pped, input logic [2:0] ph,
                       input logic [7:0] sec, input bit ack);
        vec_t v;
        v.rst = rst; v.n = n; v.sa = a; v.sb = b; v.pls_sb = psb;
        v.pls_ped = pped; v.ph = ph; v.sec = sec; v.ack = ack;
        tbl.push_back(v);
    endtask

    // Expected {ra,ya,ga,rb,yb,gb,walk} for a phase code.
    function automatic logic [6:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            3'd0:    return 7'b0011000;
            3'd1:    return 7'b0101000;
            3'd3:    return 7'b1000010;
            3'd4:    return 7'b1000100;
            3'd6:    return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [2:0] ph,
                             input logic [7:0] sec, input bit ack);
        chk("phase", idx, {29'd0, phase}, {29'd0, ph});
        chk("sec_left", idx, {24'd0, sec_left}, {24'd0, sec});
        chk("lamps", idx, {25'd0, ra, ya, ga, rb, yb, gb, walk}, {25'd0, exp_lamps(ph)});
        chk("ped_ack", idx, {31'd0, ped_ack}, {31'd0, ack});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sa = 1'b0; sb = 1'b0; ped_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Advance n clock edges from a negedge; pulses last for the first cycle.
    task automatic advance(input int n, input bit a, input bit b,
                           input bit psb, input bit pped);
        for (int i = 0; i < n; i++) begin
            sa      = a;
            sb      = b | (psb && (i == 0));
            ped_req = pped && (i == 0);
            @(posedge clk);
            @(negedge clk);
        end
        sa      = a;
        sb      = b;
        ped_req = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; sa = 1'b0; sb = 1'b0; ped_req = 1'b0;

        // No requests: A green forever, countdown to zero and hold.
        add(1, 0,   0, 0, 0, 0, 3'd0, 8'd6, 0);
        add(0, 4,   0, 0, 0, 0, 3'd0, 8'd5, 0);
        add(0, 19,  0, 0, 0, 0, 3'd0, 8'd1, 0);
        add(0, 1,   0, 0, 0, 0, 3'd0, 8'd0, 0);
        add(0, 176, 0, 0, 0, 0, 3'd0, 8'd0, 0);
        // sb pulse at cycle 5: full A->B->A cycle.
        add(1, 5,   0, 0, 0, 0, 3'd0, 8'd5, 0);
        add(0, 19,  0, 0, 1, 0, 3'd0, 8'd0, 0);
        add(0, 1,   0, 0, 0, 0, 3'd1, 8'd2, 0);
        add(0, 7,   0, 0, 0, 0, 3'd1, 8'd1, 0);
        add(0, 1,   0, 0, 0, 0, 3'd2, 8'd1, 0);
        add(0, 4,   0, 0, 0, 0, 3'd3, 8'd5, 0);
        add(0, 19,  0, 0, 0, 0, 3'd3, 8'd1, 0);
        add(0, 1,   0, 0, 0, 0, 3'd4, 8'd2, 0);
        add(0, 8,   0, 0, 0, 0, 3'd5, 8'd1, 0);
        add(0, 4,   0, 0, 0, 0, 3'd0, 8'd6, 0);
        // sb held, sa=0: two extensions then yellow despite sb.
        add(1, 37,  0, 1, 0, 0, 3'd3, 8'd5, 0);
        add(0, 20,  0, 1, 0, 0, 3'd3, 8'd2, 0);
        add(0, 7,   0, 1, 0, 0, 3'd3, 8'd1, 0);
        add(0, 1,   0, 1, 0, 0, 3'd3, 8'd2, 0);
        add(0, 8,   0, 1, 0, 0, 3'd4, 8'd2, 0);
        // Pedestrian pulse only: WALK with one-cycle ack.
        add(1, 3,   0, 0, 0, 0, 3'd0, 8'd6, 0);
        add(0, 22,  0, 0, 0, 1, 3'd1, 8'd2, 0);
        add(0, 8,   0, 0, 0, 0, 3'd2, 8'd1, 0);
        add(0, 4,   0, 0, 0, 0, 3'd6, 8'd3, 1);
        add(0, 1,   0, 0, 0, 0, 3'd6, 8'd3, 0);
        add(0, 11,  0, 0, 0, 0, 3'd7, 8'd1, 0);
        add(0, 4,   0, 0, 0, 0, 3'd0, 8'd6, 0);
        add(0, 40,  0, 0, 0, 0, 3'd0, 8'd0, 0);
        // sb plus pedestrian: B first, no extension, then WALK.
        add(1, 2,   0, 1, 0, 0, 3'd0, 8'd6, 0);
        add(0, 35,  0, 1, 0, 1, 3'd3, 8'd5, 0);
        add(0, 20,  0, 1, 0, 0, 3'd4, 8'd2, 0);
        add(0, 12,  0, 0, 0, 0, 3'd6, 8'd3, 1);
        add(0, 12,  0, 0, 0, 0, 3'd7, 8'd1, 0);
        add(0, 4,   0, 0, 0, 0, 3'd0, 8'd6, 0);
        // sa rising during an extension: not cut short, next one blocked.
        add(1, 57,  0, 1, 0, 0, 3'd3, 8'd2, 0);
        add(0, 7,   1, 1, 0, 0, 3'd3, 8'd1, 0);
        add(0, 1,   1, 1, 0, 0, 3'd4, 8'd2, 0);
        // Press on the WALK-entry cycle is kept and served again.
        add(1, 3,   0, 0, 0, 1, 3'd0, 8'd6, 0);
        add(0, 22,  0, 0, 0, 0, 3'd1, 8'd2, 0);
        add(0, 11,  0, 0, 0, 0, 3'd2, 8'd1, 0);
        add(0, 1,   0, 0, 0, 1, 3'd6, 8'd3, 1);
        add(0, 12,  0, 0, 0, 0, 3'd7, 8'd1, 0);
        add(0, 4,   0, 0, 0, 0, 3'd0, 8'd6, 0);
        add(0, 24,  0, 0, 0, 0, 3'd0, 8'd0, 0);
        add(0, 1,   0, 0, 0, 0, 3'd1, 8'd2, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            advance(tbl[i].n, tbl[i].sa, tbl[i].sb, tbl[i].pls_sb, tbl[i].pls_ped);
            check_all(i, tbl[i].ph, tbl[i].sec, tbl[i].ack);
        end

        // Asynchronous reset two cycles into B green.
        do_reset();
        advance(5, 0, 0, 0, 0);
        advance(34, 0, 0, 1, 0);
        check_all(100, 3'd3, 8'd5, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all(101, 3'd0, 8'd6, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        advance(3, 0, 0, 0, 0);
        check_all(102, 3'd0, 8'd6, 1'b0);
        advance(1, 0, 0, 0, 0);
        check_all(103, 3'd0, 8'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
